// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : receive byte FIFO (FWFT) with sticky overrun/break flags
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_valid,
  input  logic                  rx_break,
  input  logic [7:0]            rx_data,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  break_seen
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rx_valid_q, rx_break_q;
  logic                  overrun_q, overrun_d;
  logic                  break_seen_q, break_seen_d;

  logic push_req, do_push, do_pop, drop, break_set, mem_we;

  // Edge-detect valid so a level-held byte is captured once; a break masks it.
  assign push_req  = rx_valid & ~rx_valid_q & ~rx_break;
  assign break_set = rx_break & ~rx_break_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign do_pop    = pop & ~empty;
  assign do_push   = push_req & (~full | do_pop);
  assign drop      = push_req & full & ~do_pop;
  assign mem_we    = do_push & ~flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    break_seen_d = break_seen_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overrun_d    = 1'b0;
      break_seen_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
      // Set events override a same-cycle clear.
      if (clr_flags) begin
        overrun_d    = 1'b0;
        break_seen_d = 1'b0;
      end
      if (drop)      overrun_d    = 1'b1;
      if (break_set) break_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_valid_q   <= 1'b0;
      rx_break_q   <= 1'b0;
      overrun_q    <= 1'b0;
      break_seen_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rx_valid_q   <= rx_valid;
      rx_break_q   <= rx_break;
      overrun_q    <= overrun_d;
      break_seen_q <= break_seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= rx_data;
  end

  assign dout       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overrun    = overrun_q;
  assign break_seen = break_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : scoreboard bench for uart_rx_fifo
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid, rx_break, pop, flush, clr_flags;
  logic [7:0]  rx_data;
  logic [7:0]  dout;
  logic        empty, full, overrun, break_seen;
  logic [DL:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic       m_overrun;

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_break(rx_break),
    .rx_data(rx_data), .pop(pop), .flush(flush), .clr_flags(clr_flags),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .break_seen(break_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    if (sb.size() < DEPTH) sb.push_back(d);
    else m_overrun = 1'b1;
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    int n = sb.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (dout !== sb[0]) begin
        errors++;
        $display("FAIL %s_dout[%0d] got %02h exp %02h", tag, i, dout, sb[0]);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      void'(sb.pop_front());
    end
    checks++;
    if (empty !== 1'b1 || dout !== 8'h00 || count !== '0) begin
      errors++;
      $display("FAIL %s_drained got empty=%b dout=%02h count=%0d exp 1/00/0", tag, empty, dout, count);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
    pop = 1'b0; flush = 1'b0; clr_flags = 1'b0; m_overrun = 1'b0;
    tick(); tick();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || dout !== 8'h00 ||
        overrun !== 1'b0 || break_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got e=%b f=%b c=%0d d=%02h ov=%b br=%b exp 1 0 0 00 0 0",
               empty, full, count, dout, overrun, break_seen);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_capture();
    rx_data = 8'h41; rx_valid = 1'b1;
    tick();
    checks++;
    if (count !== 5'd1 || dout !== 8'h41 || empty !== 1'b0) begin
      errors++;
      $display("FAIL t1_latency got c=%0d d=%02h e=%b exp 1 41 0", count, dout, empty);
    end
    sb.push_back(8'h41);
    for (int i = 0; i < 49; i++) tick();
    checks++;
    if (count !== 5'd1) begin
      errors++;
      $display("FAIL t1_held_once got count=%0d exp 1", count);
    end
    rx_valid = 1'b0;
    tick();
    drain("t1");
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t2_full got f=%b c=%0d ov=%b exp 1 16 0", full, count, overrun);
    end
    push_byte(8'h11);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== m_overrun) begin
      errors++;
      $display("FAIL t2_overrun got f=%b c=%0d ov=%b exp 1 16 %b", full, count, overrun, m_overrun);
    end
    drain("t2");
  endtask

  task automatic test_full_push_pop();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; m_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL t3_clr got overrun=%b exp 0", overrun);
    end
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    rx_data = 8'hAA; rx_valid = 1'b1; pop = 1'b1;
    checks++;
    if (dout !== sb[0]) begin
      errors++;
      $display("FAIL t3_head got %02h exp %02h", dout, sb[0]);
    end
    tick();
    void'(sb.pop_front());
    sb.push_back(8'hAA);
    rx_valid = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t3_swap got c=%0d f=%b ov=%b exp 16 1 0", count, full, overrun);
    end
    tick();
    drain("t3");
  endtask

  task automatic test_empty_pop_wrap();
    pop = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pop = 1'b0;
    checks++;
    if (count !== '0 || empty !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t4_empty_pop got c=%0d e=%b ov=%b exp 0 1 0", count, empty, overrun);
    end
    push_byte(8'h55);
    checks++;
    if (count !== 5'd1 || dout !== 8'h55) begin
      errors++;
      $display("FAIL t4_push got c=%0d d=%02h exp 1 55", count, dout);
    end
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(8'h80 + i); rx_valid = 1'b1; pop = 1'b1;
      checks++;
      if (dout !== sb[0]) begin
        errors++;
        $display("FAIL t4_wrap[%0d] got %02h exp %02h", i, dout, sb[0]);
      end
      tick();
      void'(sb.pop_front());
      sb.push_back(8'(8'h80 + i));
      rx_valid = 1'b0; pop = 1'b0;
      tick();
    end
    checks++;
    if (count !== 5'd1) begin
      errors++;
      $display("FAIL t4_wrap_count got %0d exp 1", count);
    end
    drain("t4");
  endtask

  task automatic test_break();
    rx_data = 8'h66; rx_valid = 1'b1; rx_break = 1'b1;
    tick();
    checks++;
    if (count !== '0 || break_seen !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t5_break got c=%0d br=%b ov=%b exp 0 1 0", count, break_seen, overrun);
    end
    rx_valid = 1'b0; rx_break = 1'b0;
    tick();
    clr_flags = 1'b1; rx_break = 1'b1;
    tick();
    checks++;
    if (break_seen !== 1'b1) begin
      errors++;
      $display("FAIL t5_set_wins got break_seen=%b exp 1", break_seen);
    end
    tick();
    checks++;
    if (break_seen !== 1'b0) begin
      errors++;
      $display("FAIL t5_clr got break_seen=%b exp 0", break_seen);
    end
    clr_flags = 1'b0; rx_break = 1'b0;
    tick();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL t6_load got count=%0d exp 5", count);
    end
    rx_data = 8'h77; rx_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    checks++;
    if (count !== '0 || empty !== 1'b1 || overrun !== 1'b0 || break_seen !== 1'b0) begin
      errors++;
      $display("FAIL t6_flush got c=%0d e=%b ov=%b br=%b exp 0 1 0 0", count, empty, overrun, break_seen);
    end
    tick();
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL t6_no_recapture got count=%0d exp 0", count);
    end
    rx_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push_byte(8'(8'hD0 + i));
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL t6_async_reset got e=%b c=%0d exp 1 0", empty, count);
    end
    sb.delete();
    tick();
    resetn = 1'b1;
    tick();
    push_byte(8'h99);
    drain("t6");
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overrun();
    test_full_push_pop();
    test_empty_pop_wrap();
    test_break();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
